// File: rtl/matrix_mac_pkg.sv
// Shared types and result-narrowing helpers for the matrix multiply-accumulate engine.
// Build option: MATRIX_MAC_SATURATE_EN selects clamping instead of two's-complement wrap.
package matrix_mac_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MAC,
      DRAIN,
      WRITE,
      DONE
   } state_t;

   // Narrowing works on a 64-bit signed view, so ACC_WIDTH may not exceed 64.
   localparam int NARROW_WIDTH = 64;

   function automatic logic signed [NARROW_WIDTH-1:0] sat_max(input int data_width);
      return (64'sd1 <<< (data_width - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [NARROW_WIDTH-1:0] sat_min(input int data_width);
      return -(64'sd1 <<< (data_width - 1));
   endfunction

   function automatic logic signed [NARROW_WIDTH-1:0] narrow_result(
      input logic signed [NARROW_WIDTH-1:0] acc,
      input int                             frac_bits,
      input int                             data_width
   );
      logic signed [NARROW_WIDTH-1:0] shifted;
      shifted = acc >>> frac_bits;
`ifdef MATRIX_MAC_SATURATE_EN
      if (shifted > sat_max(data_width)) begin
         shifted = sat_max(data_width);
      end else if (shifted < sat_min(data_width)) begin
         shifted = sat_min(data_width);
      end
`else
      // Keep only the low data_width bits, sign-extended back to the full view.
      shifted = (shifted <<< (NARROW_WIDTH - data_width)) >>> (NARROW_WIDTH - data_width);
`endif
      return shifted;
   endfunction

`ifdef MATRIX_MAC_SATURATE_EN
   function automatic logic result_clamps(
      input logic signed [NARROW_WIDTH-1:0] acc,
      input int                             frac_bits,
      input int                             data_width
   );
      logic signed [NARROW_WIDTH-1:0] shifted;
      shifted = acc >>> frac_bits;
      return (shifted > sat_max(data_width)) || (shifted < sat_min(data_width));
   endfunction
`endif

endpackage

// File: rtl/matrix_mac_engine_mac_unit.sv
// Signed multiplier plus wrapping accumulator with synchronous clear/enable.
// Build option: MATRIX_MAC_SATURATE_EN adds the per-result clamp indicator.
module mac_unit
   import matrix_mac_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 40,
   parameter int FRAC_BITS  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] x_data,
   input  logic [DATA_WIDTH-1:0] y_data,
   output logic [DATA_WIDTH-1:0] result
`ifdef MATRIX_MAC_SATURATE_EN
   ,
   output logic                  sat
`endif
);

   logic signed [2*DATA_WIDTH-1:0] product;
   logic signed [ACC_WIDTH-1:0]    acc;
   logic signed [ACC_WIDTH-1:0]    acc_next;

   assign product = (2*DATA_WIDTH)'($signed(x_data)) * (2*DATA_WIDTH)'($signed(y_data));

   always_comb begin
      acc_next = acc;
      if (en) begin
         acc_next = acc + ACC_WIDTH'(product);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else begin
         acc <= acc_next;
      end
   end

   // Narrow the next accumulator value so the final product is already included
   // when the controller registers the result at the end of DRAIN.
   assign result = DATA_WIDTH'(narrow_result(64'(acc_next), FRAC_BITS, DATA_WIDTH));

`ifdef MATRIX_MAC_SATURATE_EN
   assign sat = result_clamps(64'(acc_next), FRAC_BITS, DATA_WIDTH);
`endif

endmodule

// File: rtl/matrix_mac_engine.sv
// Z = X*Y over row-major matrices in external synchronous RAMs, one element per K+2 cycles.
// Build option: MATRIX_MAC_SATURATE_EN enables output clamping and the sticky sat_flag port.
module matrix_mac_engine
   import matrix_mac_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 40,
   parameter int FRAC_BITS  = 8,
   parameter int MAX_DIM    = 64,
   parameter int DIM_WIDTH  = $clog2(MAX_DIM + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DIM_WIDTH-1:0]  x_rows,
   input  logic [DIM_WIDTH-1:0]  y_cols,
   input  logic [DIM_WIDTH-1:0]  inner_dim,
   input  logic [ADDR_WIDTH-1:0] x_base,
   input  logic [ADDR_WIDTH-1:0] y_base,
   input  logic [ADDR_WIDTH-1:0] z_base,
   output logic [ADDR_WIDTH-1:0] x_addr,
   output logic [ADDR_WIDTH-1:0] y_addr,
   input  logic [DATA_WIDTH-1:0] x_data,
   input  logic [DATA_WIDTH-1:0] y_data,
   output logic [ADDR_WIDTH-1:0] z_addr,
   output logic [DATA_WIDTH-1:0] z_data,
   output logic                  z_wen,
   output logic                  busy,
   output logic                  done,
   output logic                  dim_err
`ifdef MATRIX_MAC_SATURATE_EN
   ,
   output logic                  sat_flag
`endif
);

   state_t                state;
   logic [DIM_WIDTH-1:0]  r_dim;
   logic [DIM_WIDTH-1:0]  c_dim;
   logic [DIM_WIDTH-1:0]  k_dim;
   logic [DIM_WIDTH-1:0]  i_cnt;
   logic [DIM_WIDTH-1:0]  j_cnt;
   logic [DIM_WIDTH-1:0]  k_cnt;
   logic [ADDR_WIDTH-1:0] x_row;
   logic [ADDR_WIDTH-1:0] y_col;
   logic [ADDR_WIDTH-1:0] y_base_q;
   logic [ADDR_WIDTH-1:0] z_ptr;
   logic                  dims_bad;
   logic                  mac_clear;
   logic                  mac_en;
   logic [DATA_WIDTH-1:0] mac_result;
`ifdef MATRIX_MAC_SATURATE_EN
   logic                  mac_sat;
`endif

   assign dims_bad = (x_rows == '0)    || (x_rows > DIM_WIDTH'(MAX_DIM))
                  || (y_cols == '0)    || (y_cols > DIM_WIDTH'(MAX_DIM))
                  || (inner_dim == '0) || (inner_dim > DIM_WIDTH'(MAX_DIM));

   // Data for the address presented in one MAC cycle arrives in the next cycle,
   // so the first MAC cycle of an element only issues addresses.
   assign mac_clear = (state == IDLE) || (state == WRITE);
   assign mac_en    = ((state == MAC) && (k_cnt != '0)) || (state == DRAIN);

   mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
   ) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (mac_clear),
      .en     (mac_en),
      .x_data (x_data),
      .y_data (y_data),
      .result (mac_result)
`ifdef MATRIX_MAC_SATURATE_EN
      ,
      .sat    (mac_sat)
`endif
   );

   // Addresses advance incrementally: x by 1 and y by C within an element,
   // z by 1 per element, x_row by K per row of Z.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         r_dim    <= '0;
         c_dim    <= '0;
         k_dim    <= '0;
         i_cnt    <= '0;
         j_cnt    <= '0;
         k_cnt    <= '0;
         x_row    <= '0;
         y_col    <= '0;
         y_base_q <= '0;
         z_ptr    <= '0;
         x_addr   <= '0;
         y_addr   <= '0;
         z_addr   <= '0;
         z_data   <= '0;
         z_wen    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         dim_err  <= 1'b0;
`ifdef MATRIX_MAC_SATURATE_EN
         sat_flag <= 1'b0;
`endif
      end else begin
         done  <= 1'b0;
         z_wen <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  r_dim   <= x_rows;
                  c_dim   <= y_cols;
                  k_dim   <= inner_dim;
                  dim_err <= 1'b0;
`ifdef MATRIX_MAC_SATURATE_EN
                  sat_flag <= 1'b0;
`endif
                  if (dims_bad) begin
                     dim_err <= 1'b1;
                     done    <= 1'b1;
                     state   <= DONE;
                  end else begin
                     i_cnt    <= '0;
                     j_cnt    <= '0;
                     k_cnt    <= '0;
                     x_row    <= x_base;
                     y_col    <= y_base;
                     y_base_q <= y_base;
                     z_ptr    <= z_base;
                     x_addr   <= x_base;
                     y_addr   <= y_base;
                     busy     <= 1'b1;
                     state    <= MAC;
                  end
               end
            end

            MAC: begin
               if (k_cnt == k_dim - DIM_WIDTH'(1)) begin
                  state <= DRAIN;
               end else begin
                  k_cnt  <= k_cnt + DIM_WIDTH'(1);
                  x_addr <= x_addr + ADDR_WIDTH'(1);
                  y_addr <= y_addr + ADDR_WIDTH'(c_dim);
               end
            end

            DRAIN: begin
               z_wen  <= 1'b1;
               z_addr <= z_ptr;
               z_data <= mac_result;
`ifdef MATRIX_MAC_SATURATE_EN
               sat_flag <= sat_flag | mac_sat;
`endif
               state  <= WRITE;
            end

            WRITE: begin
               z_ptr <= z_ptr + ADDR_WIDTH'(1);
               k_cnt <= '0;
               if (j_cnt == c_dim - DIM_WIDTH'(1)) begin
                  j_cnt  <= '0;
                  y_col  <= y_base_q;
                  y_addr <= y_base_q;
                  if (i_cnt == r_dim - DIM_WIDTH'(1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     i_cnt  <= i_cnt + DIM_WIDTH'(1);
                     x_row  <= x_row + ADDR_WIDTH'(k_dim);
                     x_addr <= x_row + ADDR_WIDTH'(k_dim);
                     state  <= MAC;
                  end
               end else begin
                  j_cnt  <= j_cnt + DIM_WIDTH'(1);
                  y_col  <= y_col + ADDR_WIDTH'(1);
                  y_addr <= y_col + ADDR_WIDTH'(1);
                  x_addr <= x_row;
                  state  <= MAC;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/matrix_mac_engine.md
Name: matrix_mac_engine

Overview:
- Parametrised successor to the repeated-addition matrix multiplier: computes Z = X·Y on signed fixed-point operands held in external single-port synchronous RAMs.
- Uses a true multiply-accumulate. Matrix dimensions and base addresses are supplied at runtime, bounded by MAX_DIM.
- Sits between the DFR reservoir state RAM and the output-weight RAM: the training/inference controller starts it and waits for done.

Parameters:
- ADDR_WIDTH, 32, width of all RAM address ports.
- DATA_WIDTH, 16, signed element width of X, Y and Z.
- ACC_WIDTH, 40, signed accumulator width (≥ 2·DATA_WIDTH).
- FRAC_BITS, 8, fractional bits; the accumulator is arithmetic-shifted right by FRAC_BITS before output.
- MAX_DIM, 64, largest legal value of any runtime dimension.
- DIM_WIDTH, $clog2(MAX_DIM+1), width of the dimension ports.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- x_rows  in  DIM_WIDTH  R, rows of X
- y_cols  in  DIM_WIDTH  C, columns of Y
- inner_dim  in  DIM_WIDTH  K, columns of X = rows of Y
- x_base, y_base, z_base  in  ADDR_WIDTH  base word addresses
- x_addr, y_addr  out  ADDR_WIDTH  read addresses; registered
- x_data, y_data  in  DATA_WIDTH  read data, valid one cycle after the address
- z_addr  out  ADDR_WIDTH  write address; registered
- z_data  out  DATA_WIDTH  write data; registered
- z_wen  out  1  write strobe
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle completion pulse
- dim_err  out  1  request rejected; held until the next accepted start

Behaviour:
- Reset:
  - Asynchronous on rst_n low: all outputs 0, FSM to IDLE, accumulator and counters cleared.
  - Reset mid-operation aborts immediately. No further z_wen is issued. Z contents are undefined.
- Addressing (row-major):
  - x_addr = x_base + i·K + k
  - y_addr = y_base + k·C + j
  - z_addr = z_base + i·C + j
  - Computed incrementally (adders only, no multipliers on the address path).
- FSM states: IDLE, MAC, DRAIN, WRITE, DONE.
- IDLE:
  - On start: latch dims and bases, clear dim_err.
  - If any dim is 0 or > MAX_DIM: set dim_err, go to DONE with no RAM activity.
  - Otherwise: i=j=k=0, clear the accumulator, go to MAC.
- MAC (K cycles):
  - Cycle c presents the addresses for k=c.
  - From the second MAC cycle onward, acc += sext(x_data·y_data) for the previous k.
- DRAIN (1 cycle): accumulates the final product (k=K-1).
- WRITE (1 cycle):
  - z_wen=1; z_addr and z_data valid in the same cycle.
  - Clear the accumulator, advance j (and i when j wraps).
  - Go to MAC, or to DONE after element (R-1, C-1).
- DONE (1 cycle): done=1, busy=0, then IDLE.
- Timing:
  - Each element takes K+2 cycles.
  - From the start-sampling edge to the done cycle takes R·C·(K+2)+1 cycles.
  - Error rejection: done is asserted the cycle after start.
- start while busy: ignored; no latching.
- Arithmetic:
  - Product is signed 2·DATA_WIDTH, sign-extended to ACC_WIDTH.
  - Accumulator wraps modulo 2^ACC_WIDTH.
  - Result = acc >>> FRAC_BITS, then narrowed to DATA_WIDTH (see Optional Feature).
- Address overflow beyond ADDR_WIDTH wraps silently.

Optional Feature:
- Macro: MATRIX_MAC_SATURATE_EN.
- Defined: the shifted result clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], and a sticky sat_flag output (1 bit, cleared on start) is set if any element clamped.
- Undefined: the result is truncated to its low DATA_WIDTH bits (two's-complement wrap) and the sat_flag port is absent.

Decomposition:
- Package matrix_mac_pkg:
  - FSM state enum.
  - Saturation-limit constants derived from DATA_WIDTH.
  - Function narrow_result(acc) for shift plus truncate/saturate.
- Sub-module mac_unit:
  - Signed multiplier, accumulator register, clear/enable inputs.
  - Combinational output narrowing.
- The FSM and address counters stay in the top level.

Test Plan:
- Identity: R=C=K=2, FRAC_BITS=0, X=I, Y=[[1,2],[3,4]].
  - Z=[[1,2],[3,4]] at z_base..z_base+3.
  - Exactly 4 z_wen pulses; done 17 cycles after start.
- Signed, non-square: R=2, K=3, C=1, FRAC_BITS=8, X=[[1.0,-2.0,0.5],[−1.0,0,3.0]] (×256), Y=[2.0,1.0,4.0].
  - Z=[2.0, 10.0] → 0x0200, 0x0A00.
- Saturation: R=C=K=1, FRAC_BITS=0, x=y=0x7FFF.
  - With MATRIX_MAC_SATURATE_EN: z=0x7FFF, sat_flag=1.
  - Without: z=0x0001.
- Dimension error: K=0, then separately C=MAX_DIM+1.
  - dim_err=1, done the next cycle, z_wen never asserted.
  - A following valid start clears dim_err.
- start re-asserted during busy: no effect; identical Z and done timing to the single-start run.
- rst_n low for 1 cycle in mid-MAC of element 2.
  - All outputs 0 asynchronously; busy=0; no further z_wen.
  - A fresh start afterwards produces correct Z.
